// File: rtl/cpu_pkg.sv
// Shared types and default timing constants for the CPU-side RAM bridge.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE,
        RESP
    } t_state_bridge;

    localparam int READ_CYCLES_DEF  = 1;
    localparam int WRITE_CYCLES_DEF = 1;

endpackage

// File: rtl/cpu_mem_bridge.sv
// Valid/ready bridge from the CPU memory interface to RAM port 1, with
// programmable read-settle and write-hold cycles and a watched-address mirror.
//
// state     | meaning
// IDLE      | waiting for an enabled CPU request
// READ_WAIT | RAM read settling; samples read data on terminal count
// WRITE     | write enable held for WRITE_CYCLES, then read back
// RESP      | one-cycle ready pulse to the CPU
import cpu_pkg::*;

module cpu_mem_bridge #(
    parameter int ADDR_BITS    = 3,
    parameter int WORD_BITS    = 8,
    parameter int READ_CYCLES  = READ_CYCLES_DEF,
    parameter int WRITE_CYCLES = WRITE_CYCLES_DEF,
    parameter int WATCH_ADDR   = 0
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    input  logic                 in_cpu_valid,
    input  logic                 in_cpu_write,
    input  logic [ADDR_BITS-1:0] in_cpu_addr,
    input  logic [WORD_BITS-1:0] in_cpu_data,
    output logic                 out_cpu_ready,
    output logic [WORD_BITS-1:0] out_cpu_data,
    output logic [ADDR_BITS-1:0] out_ram_addr,
    output logic [WORD_BITS-1:0] out_ram_data,
    output logic                 out_ram_write,
    input  logic [WORD_BITS-1:0] in_ram_data,
    output logic [WORD_BITS-1:0] out_watch_data,
    output logic                 out_watch_updated,
    output logic                 out_busy
);

    localparam int CNT_MAX = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     RD_LAST = CNT_W'(READ_CYCLES);
    localparam logic [CNT_W-1:0]     WR_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] WATCH   = ADDR_BITS'(WATCH_ADDR);

    t_state_bridge        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_BITS-1:0] ram_data_q, ram_data_d;
    logic [WORD_BITS-1:0] cpu_data_q, cpu_data_d;
    logic [WORD_BITS-1:0] watch_data_q, watch_data_d;
    logic                 ready_q, ready_d;
    logic                 watch_upd_q, watch_upd_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        cpu_data_d   = cpu_data_q;
        watch_data_d = watch_data_q;
        ready_d      = 1'b0;
        watch_upd_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_enable && in_cpu_valid) begin
                    ram_addr_d = in_cpu_addr;
                    ram_data_d = in_cpu_data;
                    cnt_d      = '0;
                    state_d    = in_cpu_write ? WRITE : READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    cpu_data_d = in_ram_data;
                    cnt_d      = '0;
                    ready_d    = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                if (cnt_q == WR_LAST) begin
                    if (ram_addr_q == WATCH) begin
                        watch_data_d = ram_data_q;
                        watch_upd_d  = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = READ_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Losing the port aborts the access silently: no response, no mirror update.
        if (state_q != IDLE && !in_enable) begin
            state_d      = IDLE;
            cnt_d        = '0;
            cpu_data_d   = cpu_data_q;
            watch_data_d = watch_data_q;
            ready_d      = 1'b0;
            watch_upd_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            cpu_data_q   <= '0;
            watch_data_q <= '0;
            ready_q      <= 1'b0;
            watch_upd_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            cpu_data_q   <= cpu_data_d;
            watch_data_q <= watch_data_d;
            ready_q      <= ready_d;
            watch_upd_q  <= watch_upd_d;
            busy_q       <= busy_d;
        end
    end

    assign out_ram_write     = (state_q == WRITE) && in_enable;
    assign out_cpu_ready     = ready_q;
    assign out_cpu_data      = cpu_data_q;
    assign out_ram_addr      = ram_addr_q;
    assign out_ram_data      = ram_data_q;
    assign out_watch_data    = watch_data_q;
    assign out_watch_updated = watch_upd_q;
    assign out_busy          = busy_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: default instance plus a READ_CYCLES=3 instance.
module tb_cpu_mem_bridge;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       cpu_valid, cpu_valid3;
    logic       cpu_write;
    logic [2:0] cpu_addr;
    logic [7:0] cpu_data_in;

    logic       ready, ram_write, watch_upd, busy;
    logic [7:0] cpu_data, ram_data, watch_data, ram_rdata;
    logic [2:0] ram_addr;

    logic       ready3, ram_write3, watch_upd3, busy3;
    logic [7:0] cpu_data3, ram_data3, watch_data3, ram_rdata3;
    logic [2:0] ram_addr3;

    logic [7:0] mem  [8];
    logic [7:0] mem3 [8];

    int nchecks = 0;
    int nfail   = 0;

    cpu_mem_bridge dut (
        .in_clk(clk), .in_rst(rst_n), .in_enable(enable),
        .in_cpu_valid(cpu_valid), .in_cpu_write(cpu_write),
        .in_cpu_addr(cpu_addr), .in_cpu_data(cpu_data_in),
        .out_cpu_ready(ready), .out_cpu_data(cpu_data),
        .out_ram_addr(ram_addr), .out_ram_data(ram_data),
        .out_ram_write(ram_write), .in_ram_data(ram_rdata),
        .out_watch_data(watch_data), .out_watch_updated(watch_upd),
        .out_busy(busy)
    );

    cpu_mem_bridge #(.READ_CYCLES(3)) dut3 (
        .in_clk(clk), .in_rst(rst_n), .in_enable(enable),
        .in_cpu_valid(cpu_valid3), .in_cpu_write(cpu_write),
        .in_cpu_addr(cpu_addr), .in_cpu_data(cpu_data_in),
        .out_cpu_ready(ready3), .out_cpu_data(cpu_data3),
        .out_ram_addr(ram_addr3), .out_ram_data(ram_data3),
        .out_ram_write(ram_write3), .in_ram_data(ram_rdata3),
        .out_watch_data(watch_data3), .out_watch_updated(watch_upd3),
        .out_busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM models, read-before-write.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_data;
        ram_rdata <= mem[ram_addr];
        if (ram_write3) mem3[ram_addr3] <= ram_data3;
        ram_rdata3 <= mem3[ram_addr3];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request on the default instance; lat counts edges from the
    // accepting edge (=1) to the edge after which ready is seen.
    task automatic do_req(input logic w, input logic [2:0] a, input logic [7:0] d,
                          output int lat, output int wcnt, output int ucnt,
                          output logic [2:0] ra1, output logic [2:0] wa,
                          output logic [7:0] wd);
        cpu_valid = 1'b1; cpu_write = w; cpu_addr = a; cpu_data_in = d;
        lat = -1; wcnt = 0; ucnt = 0; ra1 = '0; wa = '0; wd = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                cpu_valid = 1'b0;
                ra1 = ram_addr;
            end
            if (ram_write) begin
                wcnt++;
                wa = ram_addr;
                wd = ram_data;
            end
            if (watch_upd) ucnt++;
            if (ready) begin
                lat = i;
                break;
            end
        end
        cpu_valid = 1'b0;
    endtask

    task automatic b2b(input bit sel, output int t1, output int t2,
                       output logic [7:0] d1, output logic [7:0] d2);
        logic rdy;
        logic [7:0] cd;
        t1 = -1; t2 = -1; d1 = '0; d2 = '0;
        cpu_addr = 3'd1; cpu_write = 1'b0;
        if (sel) cpu_valid3 = 1'b1; else cpu_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) cpu_addr = 3'd2;
            rdy = sel ? ready3 : ready;
            cd  = sel ? cpu_data3 : cpu_data;
            if (rdy) begin
                if (t1 < 0) begin
                    t1 = i; d1 = cd;
                end else begin
                    t2 = i; d2 = cd;
                    break;
                end
            end
        end
        cpu_valid = 1'b0; cpu_valid3 = 1'b0;
        tick();
    endtask

    int lat, wcnt, ucnt, t1, t2;
    logic [2:0] ra1, wa;
    logic [7:0] wd, d1, d2;

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]  = 8'(i * 8'h11);
            mem3[i] = 8'(i * 8'h11);
        end
        mem[1] = 8'h01;  mem[2] = 8'h02;  mem[3] = 8'h5A;
        mem3[1] = 8'h01; mem3[2] = 8'h02; mem3[3] = 8'h5A;
        rst_n = 1'b0; enable = 1'b0; cpu_valid = 1'b0; cpu_valid3 = 1'b0;
        cpu_write = 1'b0; cpu_addr = '0; cpu_data_in = '0;
        tick(); tick();
        chk("rst_outputs", {ready, cpu_data, ram_addr, ram_data, ram_write, watch_data, watch_upd, busy}, '0);
        rst_n = 1'b1;
        tick();

        // Disabled: requests are ignored.
        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_addr = 3'd7; cpu_data_in = 8'hAB;
        tick(); tick(); tick();
        chk("dis_busy", busy, 1'b0);
        chk("dis_write", ram_write, 1'b0);
        chk("dis_addr", ram_addr, 3'd0);
        cpu_valid = 1'b0;
        enable = 1'b1;
        tick();

        do_req(1'b0, 3'd3, 8'h00, lat, wcnt, ucnt, ra1, wa, wd);
        chk("ld3_addr", ra1, 3'd3);
        chk("ld3_lat", lat, 3);
        chk("ld3_data", cpu_data, 8'h5A);
        chk("ld3_nowrite", wcnt, 0);
        tick();
        chk("ld3_ready_pulse", ready, 1'b0);
        chk("ld3_idle", busy, 1'b0);

        do_req(1'b1, 3'd5, 8'hC3, lat, wcnt, ucnt, ra1, wa, wd);
        chk("st5_wcnt", wcnt, 1);
        chk("st5_waddr", wa, 3'd5);
        chk("st5_wdata", wd, 8'hC3);
        chk("st5_lat", lat, 4);
        chk("st5_data", cpu_data, 8'hC3);
        chk("st5_noupd", ucnt, 0);
        chk("st5_watch", watch_data, 8'h00);
        tick();

        do_req(1'b1, 3'd0, 8'h11, lat, wcnt, ucnt, ra1, wa, wd);
        chk("st0a_upd", ucnt, 1);
        chk("st0a_watch", watch_data, 8'h11);
        chk("st0a_lat", lat, 4);
        tick();
        do_req(1'b1, 3'd0, 8'h22, lat, wcnt, ucnt, ra1, wa, wd);
        chk("st0b_upd", ucnt, 1);
        chk("st0b_watch", watch_data, 8'h22);
        chk("st0b_data", cpu_data, 8'h22);
        tick();

        b2b(1'b0, t1, t2, d1, d2);
        chk("b2b_t1", t1, 3);
        chk("b2b_gap", t2 - t1, 4);
        chk("b2b_d1", d1, 8'h01);
        chk("b2b_d2", d2, 8'h02);
        b2b(1'b1, t1, t2, d1, d2);
        chk("b2b3_t1", t1, 5);
        chk("b2b3_gap", t2 - t1, 6);
        chk("b2b3_d1", d1, 8'h01);
        chk("b2b3_d2", d2, 8'h02);
        chk("b2b3_idle", busy3, 1'b0);
        tick();

        // Enable dropped in READ_WAIT.
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 3'd3;
        tick();
        cpu_valid = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        chk("abrt_rd_busy", busy, 1'b0);
        chk("abrt_rd_ready", ready, 1'b0);
        tick(); tick();
        chk("abrt_rd_ready2", ready, 1'b0);
        chk("abrt_rd_data", cpu_data, 8'h02);
        enable = 1'b1;
        tick();

        // Enable dropped in WRITE.
        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_addr = 3'd6; cpu_data_in = 8'h99;
        tick();
        cpu_valid = 1'b0;
        chk("abrt_wr_we_on", ram_write, 1'b1);
        enable = 1'b0;
        #1;
        chk("abrt_wr_we_off", ram_write, 1'b0);
        tick();
        chk("abrt_wr_busy", busy, 1'b0);
        chk("abrt_wr_watch", watch_data, 8'h22);
        enable = 1'b1;
        tick();
        do_req(1'b0, 3'd6, 8'h00, lat, wcnt, ucnt, ra1, wa, wd);
        chk("abrt_wr_mem", cpu_data, 8'h66);
        tick();

        // Reset mid-store.
        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_addr = 3'd4; cpu_data_in = 8'hEE;
        tick();
        cpu_valid = 1'b0;
        chk("rstw_we_on", ram_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_we_off", ram_write, 1'b0);
        chk("rstw_outputs", {ready, cpu_data, ram_addr, ram_data, ram_write, watch_data, watch_upd, busy}, '0);
        tick();
        rst_n = 1'b1;
        tick();
        do_req(1'b0, 3'd0, 8'h00, lat, wcnt, ucnt, ra1, wa, wd);
        chk("rstw_ld0_lat", lat, 3);
        chk("rstw_ld0_data", cpu_data, 8'h22);
        tick();
        do_req(1'b0, 3'd4, 8'h00, lat, wcnt, ucnt, ra1, wa, wd);
        chk("rstw_ld4_data", cpu_data, 8'h44);
        chk("dut3_watch", {watch_data3, watch_upd3, ram_data3}, '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Handshake bridge between the CPU memory interface (valid/ready/write) and port 1 of the synchronous single-port RAM.
- Inserts a configurable number of read-settle and write-hold cycles.
- Writes the CPU's store data and returns a read-back word on every access.
- Tracks one watched address for debug LEDs; sits between the CPU and the RAM port multiplexer that hands the port to the ROM copier during boot.

Parameters:
- ADDR_BITS, 3, RAM address width.
- WORD_BITS, 8, data word width.
- READ_CYCLES, 1, extra cycles held in READ_WAIT before RAM data is sampled (legal: ≥1).
- WRITE_CYCLES, 1, cycles out_ram_write stays high per store (legal: ≥1).
- WATCH_ADDR, 0, address whose stores are mirrored to out_watch_data.

Ports:
- in_clk, in, 1, system clock.
- in_rst, in, 1, asynchronous active-low reset.
- in_enable, in, 1, bridge owns the RAM port (high only in the RUN_CPU phase).
- in_cpu_valid, in, 1, CPU request valid.
- in_cpu_write, in, 1, 1 = store, 0 = load.
- in_cpu_addr, in, ADDR_BITS, request address.
- in_cpu_data, in, WORD_BITS, store data.
- out_cpu_ready, out, 1, one-cycle completion pulse.
- out_cpu_data, out, WORD_BITS, load / read-back data (registered).
- out_ram_addr, out, ADDR_BITS, RAM address (registered).
- out_ram_data, out, WORD_BITS, RAM write data (registered).
- out_ram_write, out, 1, RAM write enable.
- in_ram_data, in, WORD_BITS, RAM read data (one-cycle synchronous read).
- out_watch_data, out, WORD_BITS, last value stored to WATCH_ADDR.
- out_watch_updated, out, 1, one-cycle pulse when out_watch_data changes source.
- out_busy, out, 1, state ≠ IDLE.

Behaviour:
- Reset (in_rst = 0, asynchronous):
  - State goes to IDLE and the counter clears.
  - All outputs reset to 0: ready, cpu_data, ram_addr, ram_data, ram_write, watch_data, watch_updated, busy.
- States: IDLE, READ_WAIT, WRITE, RESP.
- IDLE:
  - On an edge with in_enable & in_cpu_valid: latch addr into out_ram_addr and in_cpu_data into out_ram_data, latch the write flag, clear cnt.
  - Next state is WRITE if write, else READ_WAIT.
  - Requests are ignored while in_enable = 0.
- READ_WAIT:
  - cnt increments each cycle. When cnt == READ_CYCLES: out_cpu_data <= in_ram_data, cnt clears, go RESP.
  - Duration is READ_CYCLES+1 cycles.
- WRITE:
  - out_ram_write = 1 (combinational from state & in_enable). cnt counts 0..WRITE_CYCLES-1, so the enable is high for exactly WRITE_CYCLES cycles.
  - On the last cycle, if the latched addr == WATCH_ADDR: out_watch_data <= latched data and out_watch_updated pulses one cycle.
  - Then clear cnt and go READ_WAIT (read-back, so the CPU receives the stored value).
- RESP:
  - out_cpu_ready = 1 for exactly one cycle, then IDLE.
  - The CPU drops valid or presents a new request on the next cycle; valid high in IDLE is always a new request. Back-to-back requests need no idle gap beyond RESP.
- Load latency: ready is asserted READ_CYCLES+2 cycles after the accepting edge (3 with the defaults).
- Store latency: WRITE_CYCLES+READ_CYCLES+2 cycles (4 with the defaults).
- in_enable falling mid-transaction:
  - out_ram_write drops combinationally in the same cycle.
  - State returns to IDLE on the next edge. No ready pulse and no watch update for the aborted access; out_cpu_data is unchanged.
- Counter width: $clog2(max(READ_CYCLES, WRITE_CYCLES)+1). It never wraps, because the compare terminates it.
- Address and data pass through unmodified; there is no arithmetic on them.
- Signals ignored outside IDLE: in_cpu_addr, in_cpu_data, in_cpu_write. Only latched values are used.

Decomposition:
- Shared package cpu_pkg holds:
  - t_state_bridge enum (IDLE, READ_WAIT, WRITE, RESP).
  - Default constants: READ_CYCLES_DEF = 1, WRITE_CYCLES_DEF = 1.
- No sub-module is natural; implement as a single module with one always_ff and one always_comb.

Test Plan:
- Reset mid-store (in_rst low during WRITE) -> out_ram_write falls immediately and all outputs are 0. After release, a load of addr 0 proceeds normally.
- RAM preloaded [3] = 0x5A; load addr 3 -> out_ram_addr = 3 one cycle after acceptance; ready pulses 3 cycles after acceptance with out_cpu_data = 0x5A.
- Store 0xC3 to addr 5 (WATCH_ADDR = 0) -> out_ram_write high exactly 1 cycle with addr 5 / data 0xC3; ready 4 cycles after acceptance with out_cpu_data = 0xC3; out_watch_updated stays 0.
- Store 0x11 to addr 0 -> watch_data = 0x11 with a single-cycle updated pulse; a following store of 0x22 to addr 0 gives watch_data = 0x22.
- Back-to-back loads of addr 1 (0x01) and addr 2 (0x02), with valid held high across RESP -> two ready pulses 4 cycles apart returning 0x01 then 0x02. With READ_CYCLES = 3, the spacing becomes 6 cycles.
- in_enable dropped in READ_WAIT -> no ready pulse, out_busy = 0 next cycle. With in_enable = 0 and valid = 1, the bridge stays IDLE and out_ram_write stays 0.
